fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage controller for the five-stage ARM pipeline. It consumes the stall, IFID_Write and PCWrite controls from the hazard unit and the taken-branch redirect from EX. It owns the PC register and the IF/ID pipeline register, and drives the bubble that the ID/EX latch turns into a NOP. It also runs the halt-drain sequence and keeps a saturating stall-cycle performance counter.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- DRAIN_CYCLES, 3: cycles spent in DRAIN after a halt is accepted (covers EX/MEM/WB).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- stall  in  1  hazard unit: insert bubble into ID/EX this cycle.
- IFID_Write  in  1  hazard unit: 1 = IF/ID register may load.
- PCWrite  in  1  hazard unit: 1 = PC may advance.
- br_taken  in  1  EX: taken branch this cycle.
- br_target  in  32  EX: branch target. Bits [1:0] are ignored and forced to 0.
- halt  in  1  decode: the IF/ID instruction is a valid halt (SWI) and is not stalled.
- imem_inst  in  32  instruction at pc_out. Combinational read, same cycle.
- pc_out  out  32  current fetch PC / imem address.
- ifid_inst  out  32  IF/ID instruction.
- ifid_pc  out  32  PC of the IF/ID instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- bubble  out  1  combinational: ID/EX loads a NOP this cycle.
- halted  out  1  pipeline fully drained after a halt.
- stall_cycles  out  16  saturating count of stall cycles in RUN.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Per-cycle priority in RUN: rst, then br_taken, then halt, then hazard controls, then normal advance.
- br_taken:
  - pc_out <= {br_target[31:2], 2'b00}.
  - ifid_valid <= 0 (wrong-path flush).
  - Overrides PCWrite=0, IFID_Write=0 and halt, because the instruction in ID is wrong-path.
- halt (no br_taken):
  - PC frozen, ifid_valid <= 0.
  - drain_cnt <= DRAIN_CYCLES-1, state <= DRAIN.
- PCWrite=0: pc_out holds.
- IFID_Write=0: ifid_inst, ifid_pc and ifid_valid hold.
- Normal advance:
  - pc_out <= pc_out + 4, wrapping modulo 2^32.
  - ifid_inst <= imem_inst, ifid_pc <= pc_out, ifid_valid <= 1.
- DRAIN:
  - PC and IF/ID frozen, ifid_valid stays 0.
  - br_taken, halt, stall, PCWrite and IFID_Write are ignored.
  - drain_cnt decrements each cycle; when drain_cnt == 0, state <= HALTED.
- HALTED:
  - halted = 1, all state frozen.
  - Exit only by rst.
- bubble = stall | br_taken | ~ifid_valid | (state != RUN).
- stall_cycles:
  - +1 on each cycle with stall=1 in RUN.
  - Saturates at 16'hFFFF.
  - Not incremented in DRAIN or HALTED.

## Timing
- Reset values:
  - pc_out = RESET_PC.
  - ifid_inst = 0, ifid_pc = 0, ifid_valid = 0.
  - halted = 0, stall_cycles = 0, state = RUN.
  - bubble = 1 while ifid_valid = 0.
- rst asserted mid-DRAIN or in HALTED returns everything to reset values on the next edge.
- Fetch latency: the instruction at pc_out appears on ifid_inst one edge later.
  - First valid IF/ID is the first edge after rst deasserts.
- Redirect: br_taken at cycle N gives pc_out = target at N+1 and ifid_valid = 0 at N+1.
  - Target instruction is valid in IF/ID at N+2.
  - Branch penalty is 2 bubbles.
- Stall: with PCWrite=0 and IFID_Write=0 at cycle N, both registers hold at N+1, and bubble=1 during N.
- Halt accepted at N:
  - DRAIN from N+1 through N+DRAIN_CYCLES.
  - halted = 1 from N+DRAIN_CYCLES+1.
- Simultaneous br_taken and halt: branch wins and state stays RUN.

## Test plan
- Reset, then 4 free-running cycles with imem_inst = pc-derived pattern:
  - pc_out goes 0x0, 0x4, 0x8, 0xC.
  - ifid_pc lags by one cycle.
  - ifid_valid = 1 from cycle 1.
  - bubble = 1 only in cycle 0.
- Hold stall=1, PCWrite=0, IFID_Write=0 for 3 cycles with pc_out = 0x10:
  - pc_out stays 0x10, ifid_inst is unchanged.
  - bubble = 1 throughout, stall_cycles = 3.
  - Release: pc_out = 0x14 next cycle.
- br_taken=1, br_target=0x0000_0103, while PCWrite=0:
  - pc_out = 0x100 next cycle, ifid_valid = 0.
  - Instruction from 0x100 valid in IF/ID the cycle after.
- halt=1 at cycle N:
  - bubble = 1 for N+1 through N+3.
  - halted = 1 at N+4.
  - Later br_taken has no effect on pc_out.
  - rst returns pc_out to RESET_PC and halted to 0.
- halt=1 and br_taken=1 in the same cycle: state stays RUN, pc_out = target, halted never asserts.
- Preload stall_cycles near saturation (force it, or run 65540 stall cycles): value sticks at 0xFFFF.
- pc_out = 0xFFFF_FFFC, then advance: pc_out = 0x0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/EX/decode controls in, PC, IF/ID and status out.
// The master modport is the fetch controller; the slave modport is its environment.
interface fetch_if;
    logic        stall;
    logic        IFID_Write;
    logic        PCWrite;
    logic        br_taken;
    logic [31:0] br_target;
    logic        halt;
    logic [31:0] imem_inst;
    logic [31:0] pc_out;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        bubble;
    logic        halted;
    logic [15:0] stall_cycles;

    modport master (
        input  stall, IFID_Write, PCWrite, br_taken, br_target, halt, imem_inst,
        output pc_out, ifid_inst, ifid_pc, ifid_valid, bubble, halted, stall_cycles
    );

    modport slave (
        output stall, IFID_Write, PCWrite, br_taken, br_target, halt, imem_inst,
        input  pc_out, ifid_inst, ifid_pc, ifid_valid, bubble, halted, stall_cycles
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC and IF/ID registers, branch redirect, halt-drain FSM
// and a saturating stall-cycle counter.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 3
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  bus
);
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   drain_cnt, cnt_nxt;
    logic [31:0]        pc, inst, inst_pc;
    logic               valid;
    logic [15:0]        stall_cnt;
    logic               redirect, flush, pc_adv, ifid_load, count_stall;
    logic               bubble, halted;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= cnt_nxt;
        end
    end

    // A branch in EX outranks a halt in ID: the halting instruction is wrong-path.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = drain_cnt;
        case (state)
            RUN: begin
                if (!bus.br_taken && bus.halt) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) state_nxt = HALTED;
                else                 cnt_nxt   = drain_cnt - CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        redirect    = 1'b0;
        flush       = 1'b0;
        pc_adv      = 1'b0;
        ifid_load   = 1'b0;
        count_stall = 1'b0;
        if (state == RUN) begin
            redirect    = bus.br_taken;
            flush       = bus.br_taken | bus.halt;
            pc_adv      = !flush && bus.PCWrite;
            ifid_load   = !flush && bus.IFID_Write;
            count_stall = bus.stall;
        end
        bubble = bus.stall | bus.br_taken | ~valid | (state != RUN);
        halted = (state == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            inst      <= '0;
            inst_pc   <= '0;
            valid     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (redirect)    pc <= bus.br_target & 32'hFFFF_FFFC;
            else if (pc_adv) pc <= pc + 32'd4;

            if (flush) begin
                valid <= 1'b0;
            end else if (ifid_load) begin
                inst    <= bus.imem_inst;
                inst_pc <= pc;
                valid   <= 1'b1;
            end

            if (count_stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign bus.pc_out       = pc;
    assign bus.ifid_inst    = inst;
    assign bus.ifid_pc      = inst_pc;
    assign bus.ifid_valid   = valid;
    assign bus.bubble       = bubble;
    assign bus.halted       = halted;
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_fetch_ctrl;
    localparam int DRAIN_CYCLES = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    assign bus.imem_inst = imem_word(bus.pc_out);

    // Reference model: mode 0 = running, 1 = draining, 2 = halted.
    logic [31:0] m_pc, m_inst, m_ipc;
    logic        m_valid;
    int          m_mode;
    int          m_left;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic pw, input logic iw,
                         input logic br, input logic [31:0] tgt, input logic h);
        rst            = r;
        bus.stall      = st;
        bus.PCWrite    = pw;
        bus.IFID_Write = iw;
        bus.br_taken   = br;
        bus.br_target  = tgt;
        bus.halt       = h;
    endtask

    task automatic model_edge();
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (rst) begin
            m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_valid = 1'b0;
            m_mode = 0; m_left = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (bus.stall) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (bus.br_taken) begin
                m_pc    = {bus.br_target[31:2], 2'b00};
                m_valid = 1'b0;
            end else if (bus.halt) begin
                m_valid = 1'b0;
                m_mode  = 1;
                m_left  = DRAIN_CYCLES;
            end else begin
                if (bus.PCWrite) m_pc = old_pc + 32'd4;
                if (bus.IFID_Write) begin
                    m_inst  = imem_word(old_pc);
                    m_ipc   = old_pc;
                    m_valid = 1'b1;
                end
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
    endtask

    // Compare against the model mid-cycle, then clock one edge.
    task automatic step(input bit do_chk);
        #1;
        if (do_chk) begin
            chk("pc_out", bus.pc_out, m_pc);
            chk("ifid_inst", bus.ifid_inst, m_inst);
            chk("ifid_pc", bus.ifid_pc, m_ipc);
            chk("ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_valid});
            chk("bubble", {31'b0, bus.bubble},
                {31'b0, bus.stall | bus.br_taken | ~m_valid | (m_mode != 0)});
            chk("halted", {31'b0, bus.halted}, {31'b0, m_mode == 2});
            chk("stall_cycles", {16'b0, bus.stall_cycles}, m_cnt);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    logic [31:0] saved;

    initial begin
        checks = 0;
        failures = 0;
        m_pc = 0; m_inst = 0; m_ipc = 0; m_valid = 0; m_mode = 0; m_left = 0; m_cnt = 0;
        drive(1, 0, 1, 1, 0, 32'h0, 0);
        @(negedge clk);
        step(0);
        #1;
        chk("rst_pc", bus.pc_out, 32'h0);
        chk("rst_valid", {31'b0, bus.ifid_valid}, 32'h0);
        chk("rst_inst", bus.ifid_inst, 32'h0);
        chk("rst_bubble", {31'b0, bus.bubble}, 32'h1);
        chk("rst_halted", {31'b0, bus.halted}, 32'h0);
        chk("rst_stallcnt", {16'b0, bus.stall_cycles}, 32'h0);

        // Free-running fetch
        drive(0, 0, 1, 1, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("free_pc", bus.pc_out, 32'(i * 4));
            chk("free_bubble", {31'b0, bus.bubble}, (i == 0) ? 32'h1 : 32'h0);
            if (i > 0) begin
                chk("free_ifid_pc", bus.ifid_pc, 32'((i - 1) * 4));
                chk("free_valid", {31'b0, bus.ifid_valid}, 32'h1);
            end
            step(1);
        end

        // Hazard stall for three cycles at 0x10
        #1;
        saved = bus.ifid_inst;
        drive(0, 1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc", bus.pc_out, 32'h10);
            chk("stall_inst", bus.ifid_inst, saved);
            chk("stall_bubble", {31'b0, bus.bubble}, 32'h1);
            step(1);
        end
        #1;
        chk("stall_count", {16'b0, bus.stall_cycles}, 32'd3);
        drive(0, 0, 1, 1, 0, 32'h0, 0);
        step(1);
        #1;
        chk("stall_release_pc", bus.pc_out, 32'h14);

        // Branch overrides PCWrite=0
        drive(0, 0, 0, 1, 1, 32'h0000_0103, 0);
        step(1);
        #1;
        chk("br_pc", bus.pc_out, 32'h100);
        chk("br_valid", {31'b0, bus.ifid_valid}, 32'h0);
        drive(0, 0, 1, 1, 0, 32'h0, 0);
        step(1);
        #1;
        chk("br_tgt_ifid_pc", bus.ifid_pc, 32'h100);
        chk("br_tgt_inst", bus.ifid_inst, imem_word(32'h100));
        chk("br_tgt_valid", {31'b0, bus.ifid_valid}, 32'h1);

        // Halt and drain
        drive(0, 0, 1, 1, 0, 32'h0, 1);
        step(1);
        drive(0, 0, 1, 1, 0, 32'h0, 0);
        for (int k = 1; k <= DRAIN_CYCLES; k++) begin
            #1;
            chk("drain_bubble", {31'b0, bus.bubble}, 32'h1);
            chk("drain_halted", {31'b0, bus.halted}, 32'h0);
            step(1);
        end
        #1;
        chk("halted", {31'b0, bus.halted}, 32'h1);
        saved = bus.pc_out;
        drive(0, 0, 1, 1, 1, 32'h0000_0200, 0);
        step(1);
        #1;
        chk("halted_br_pc", bus.pc_out, saved);
        drive(1, 0, 1, 1, 0, 32'h0, 0);
        step(1);
        #1;
        chk("halt_rst_pc", bus.pc_out, 32'h0);
        chk("halt_rst_halted", {31'b0, bus.halted}, 32'h0);

        // Simultaneous halt and branch: branch wins
        drive(0, 0, 1, 1, 0, 32'h0, 0);
        step(1);
        step(1);
        drive(0, 0, 1, 1, 1, 32'h0000_0040, 1);
        step(1);
        #1;
        chk("brhalt_pc", bus.pc_out, 32'h40);
        drive(0, 0, 1, 1, 0, 32'h0, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("brhalt_nohalt", {31'b0, bus.halted}, 32'h0);
            step(1);
        end

        // PC wrap
        drive(0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0);
        step(1);
        #1;
        chk("wrap_top", bus.pc_out, 32'hFFFF_FFFC);
        drive(0, 0, 1, 1, 0, 32'h0, 0);
        step(1);
        #1;
        chk("wrap_zero", bus.pc_out, 32'h0);

        // Stall counter saturation
        drive(0, 1, 1, 1, 0, 32'h0, 0);
        for (int i = 0; i < 65540; i++) step(0);
        #1;
        chk("sat_cnt", {16'b0, bus.stall_cycles}, 32'hFFFF);
        step(1);
        #1;
        chk("sat_cnt_hold", {16'b0, bus.stall_cycles}, 32'hFFFF);

        // Random traffic against the model
        drive(1, 0, 1, 1, 0, 32'h0, 0);
        step(0);
        for (int i = 0; i < 3000; i++) begin
            logic st;
            st = ($urandom_range(0, 3) == 0);
            drive(($urandom_range(0, 63) == 0),
                  st,
                  st ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0),
                  st ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) == 0),
                  $urandom(),
                  ($urandom_range(0, 23) == 0));
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
